trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Parametrised, sequential successor to the combinational exception detector. It arbitrates synchronous exceptions from `NUM_SRC` pipeline stages and, optionally, pending interrupts. The winning trap is captured in a register, a pipeline-flush handshake is run, and the trap is then presented to the CSR file through a valid/ready handshake. The block sits between the pipeline stages and the CSR/trap-entry logic in `rtl/core`.

## Interface
- `XLEN`, default `XLEN` macro value: data/address width (32 or 64).
- `NUM_SRC`, default 4: number of exception sources; index 0 is the oldest stage and has the highest priority.
- `CNT_W`, default 16: width of the trap counter.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `current_priv`  in  2  current privilege mode (00 U, 01 S, 11 M).
- `src_valid`  in  NUM_SRC  per-source exception request.
- `src_cause`  in  5*NUM_SRC  packed cause codes; source i occupies bits [5i+4:5i].
- `src_pc`  in  XLEN*NUM_SRC  packed faulting PCs.
- `src_tval`  in  XLEN*NUM_SRC  packed trap values.
- `irq_pending`  in  12  mip & mie, bit-indexed by interrupt cause.
- `irq_global_en`  in  1  effective global interrupt enable.
- `irq_pc`  in  XLEN  PC of the oldest uncommitted instruction.
- `flush_req`  out  1  request a pipeline flush.
- `flush_done`  in  1  pipeline has flushed.
- `trap_valid`  out  1  trap payload valid.
- `trap_ready`  in  1  CSR file accepts the trap.
- `trap_irq`  out  1  trap is an interrupt.
- `trap_cause`  out  5  final cause code.
- `trap_pc`  out  XLEN  epc value.
- `trap_tval`  out  XLEN  tval value.
- `busy`  out  1  state is not IDLE.
- `trap_count`  out  CNT_W  saturating count of accepted traps.

## Operation
- FSM states are IDLE, FLUSH and COMMIT.
- **IDLE**
  - Select the lowest index i with `src_valid[i]`.
  - If none is set and interrupts are taken (`irq_global_en` && `|irq_pending`), take the highest-priority interrupt in the order 11, 3, 7, 9, 1, 5. Other pending bits are ignored.
  - Exceptions always win over interrupts in the same cycle.
  - When a trap is selected, capture the payload into registers and go to FLUSH.
- **ECALL rewrite:** a source cause of 8 is replaced by 8 + `current_priv`, where priv 10 maps to 11. The priv value sampled is the one in the capture cycle.
- **Interrupt payload:** `trap_pc` = `irq_pc`, `trap_tval` = 0, `trap_irq` = 1.
- **FLUSH**
  - `flush_req` = 1 until `flush_done` is seen; then go to COMMIT.
  - All `src_valid` are ignored while in this state.
- **COMMIT**
  - `trap_valid` = 1 with the payload held stable until `trap_ready`.
  - On `trap_ready`, increment `trap_count` (saturating at all-ones) and return to IDLE.
- `busy` = (state != IDLE).

## Timing
- **Reset values:** state IDLE; `flush_req`, `trap_valid` and `trap_irq` are 0; `trap_cause`, `trap_pc`, `trap_tval` and `trap_count` are 0; `busy` is 0.
- **Latency:**
  - Request sampled at edge N.
  - `flush_req` is high in cycle N+1.
  - With `flush_done` in N+1, `trap_valid` is high in N+2.
  - With `trap_ready` in N+2, IDLE is reached in N+3 and a new request can be captured at that edge.
- `flush_done` or `trap_ready` asserted outside their owning state has no effect.
- Sources held valid across a trap are re-arbitrated only after IDLE is re-entered.
- A reset asserted mid-FLUSH or mid-COMMIT aborts the trap immediately. There is no partial handshake completion.
- `trap_count` is held at 2^CNT_W − 1 once it saturates.

## Configuration
- Macro: `TRAP_IRQ_EN`.
- **Defined:** interrupt arbitration as described under Operation.
- **Undefined:**
  - `irq_pending`, `irq_global_en` and `irq_pc` are unused.
  - `trap_irq` is constant 0.
  - Only exceptions are sequenced.

## Structure
- Shared header `rtl/core/trap_defs.vh` holds:
  - cause localparams, both exception and interrupt codes;
  - the FSM state encodings;
  - the interrupt priority order.
- Sub-module `irq_priority_enc` is a combinational 12-bit encoder producing a found flag and a 5-bit cause. It is instantiated only under `TRAP_IRQ_EN`.

## Test plan
- **Single exception:**
  - Stimulus: `src_valid` = 0100, cause 2, pc 0x100, tval 0xDEAD; `flush_done` held high; `trap_ready` held high.
  - Response: `trap_valid` in N+2 with cause 2, pc 0x100, tval 0xDEAD; `trap_count` = 1.
- **Source priority:**
  - Stimulus: `src_valid` = 1010; source 1 cause 13, source 3 cause 3.
  - Response: cause 13 with source 1's pc/tval.
- **ECALL rewrite:**
  - Stimulus: cause 8 with priv 00, then 01, then 11.
  - Response: `trap_cause` 8, then 9, then 11.
- **Interrupt priority (`TRAP_IRQ_EN`):**
  - Stimulus 1: `irq_pending` = 0x0A0 (bits 5 and 7), `irq_global_en` = 1, `irq_pc` = 0x200.
  - Response 1: `trap_irq` = 1, cause 7, pc 0x200, tval 0.
  - Stimulus 2: same cycle with `src_valid[0]` set.
  - Response 2: the exception wins.
- **Handshake stall:**
  - Stimulus: `flush_done` held low for 5 cycles, then `trap_ready` held low for 3 cycles; new `src_valid` asserted during both waits.
  - Response: `flush_req` held for 5 cycles, then the payload is stable for 3 cycles; new requests are ignored until IDLE.
- **Reset mid-COMMIT:**
  - Stimulus: reset asserted while `trap_valid` = 1.
  - Response: all outputs return to their reset values asynchronously; `trap_count` is unchanged from 0 if this was the first trap.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trap_sequencer_pkg
// Shared definitions for the trap sequencer:
//   - default data width (taken from the XLEN macro, 32 if not supplied)
//   - FSM state encodings
//   - exception and interrupt cause codes
//   - interrupt priority order, highest priority first
//   - the ECALL cause rewrite helper
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package trap_sequencer_pkg;

    localparam int XLEN_DEFAULT = `XLEN;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Exception cause codes
    localparam logic [4:0] CAUSE_MISALIGN_FETCH = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL_INSN   = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT     = 5'd3;
    localparam logic [4:0] CAUSE_ECALL_U        = 5'd8;
    localparam logic [4:0] CAUSE_ECALL_S        = 5'd9;
    localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;

    // Interrupt cause codes (bit index into mip/mie)
    localparam logic [3:0] IRQ_S_SW    = 4'd1;
    localparam logic [3:0] IRQ_M_SW    = 4'd3;
    localparam logic [3:0] IRQ_S_TIMER = 4'd5;
    localparam logic [3:0] IRQ_M_TIMER = 4'd7;
    localparam logic [3:0] IRQ_S_EXT   = 4'd9;
    localparam logic [3:0] IRQ_M_EXT   = 4'd11;

    // Interrupt priority, entry 0 is the highest priority
    localparam int IRQ_NUM_PRIO = 6;
    localparam logic [3:0] IRQ_PRIO [IRQ_NUM_PRIO] = '{
        IRQ_M_EXT, IRQ_M_SW, IRQ_M_TIMER, IRQ_S_EXT, IRQ_S_SW, IRQ_S_TIMER
    };

    // The pipeline reports every environment call as cause 8; the real cause
    // depends on the privilege level the call was made from. The reserved
    // privilege encoding 2'b10 is treated as machine mode.
    function automatic logic [4:0] ecall_rewrite(input logic [4:0] cause,
                                                 input logic [1:0] priv);
        logic [4:0] res;
        res = cause;
        if (cause == CAUSE_ECALL_U) begin
            case (priv)
                2'b00:   res = CAUSE_ECALL_U;
                2'b01:   res = CAUSE_ECALL_S;
                default: res = CAUSE_ECALL_M;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// -----------------------------------------------------------------------------
// irq_priority_enc
// Combinational priority encoder over the 12 pending-interrupt bits.
// Only causes 11, 3, 7, 9, 1, 5 (in that priority order) are considered;
// every other pending bit is ignored.
// Ports:
//   pending  in  12  mip & mie, bit-indexed by interrupt cause
//   found    out 1   at least one prioritised interrupt is pending
//   cause    out 5   cause code of the winning interrupt (0 when none)
// -----------------------------------------------------------------------------
module irq_priority_enc
    import trap_sequencer_pkg::*;
(
    input  logic [11:0] pending,
    output logic        found,
    output logic [4:0]  cause
);

    // Walk from lowest to highest priority so the highest one overwrites.
    always_comb begin
        found = 1'b0;
        cause = 5'd0;
        for (int i = IRQ_NUM_PRIO - 1; i >= 0; i--) begin
            if (pending[IRQ_PRIO[i]]) begin
                found = 1'b1;
                cause = {1'b0, IRQ_PRIO[i]};
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
// Arbitrates synchronous exceptions from NUM_SRC pipeline stages (index 0 is
// the oldest and wins) and, when built with TRAP_IRQ_EN defined, pending
// interrupts. The winning trap is captured, a pipeline flush handshake is
// run, and the trap is then offered to the CSR file over valid/ready.
// Build option:
//   TRAP_IRQ_EN  defined   -> interrupts are arbitrated (exceptions still win)
//                undefined -> irq_* inputs unused, trap_irq constant 0
// Ports:
//   clk, reset (async, active-high)
//   current_priv            privilege mode used for the ECALL cause rewrite
//   src_valid/cause/pc/tval packed per-source exception requests
//   irq_pending/global_en/pc interrupt inputs
//   flush_req / flush_done  pipeline flush handshake
//   trap_valid / trap_ready trap hand-off to the CSR file
//   trap_irq/cause/pc/tval  captured trap payload
//   busy                    sequencer is not idle
//   trap_count              saturating count of accepted traps
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN    = `XLEN,
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              current_priv,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [5*NUM_SRC-1:0]    src_cause,
    input  logic [XLEN*NUM_SRC-1:0] src_pc,
    input  logic [XLEN*NUM_SRC-1:0] src_tval,
    input  logic [11:0]             irq_pending,
    input  logic                    irq_global_en,
    input  logic [XLEN-1:0]         irq_pc,
    output logic                    flush_req,
    input  logic                    flush_done,
    output logic                    trap_valid,
    input  logic                    trap_ready,
    output logic                    trap_irq,
    output logic [4:0]              trap_cause,
    output logic [XLEN-1:0]         trap_pc,
    output logic [XLEN-1:0]         trap_tval,
    output logic                    busy,
    output logic [CNT_W-1:0]        trap_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0] state;

    // Oldest valid source: scan from youngest to oldest, oldest overwrites.
    logic            exc_found;
    logic [4:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;

    always_comb begin
        exc_found = 1'b0;
        exc_cause = 5'd0;
        exc_pc    = '0;
        exc_tval  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                exc_found = 1'b1;
                exc_cause = src_cause[5*i +: 5];
                exc_pc    = src_pc[XLEN*i +: XLEN];
                exc_tval  = src_tval[XLEN*i +: XLEN];
            end
        end
    end

`ifdef TRAP_IRQ_EN
    logic       irq_found;
    logic [4:0] irq_cause;

    irq_priority_enc u_irq_enc (
        .pending (irq_pending),
        .found   (irq_found),
        .cause   (irq_cause)
    );
`else
    logic unused_irq;
    assign unused_irq = ^{irq_pending, irq_global_en, irq_pc};
`endif

    // Candidate payload for capture in IDLE
    logic            cap_take;
    logic            cap_irq;
    logic [4:0]      cap_cause;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] cap_tval;

    always_comb begin
        cap_take  = exc_found;
        cap_irq   = 1'b0;
        cap_cause = ecall_rewrite(exc_cause, current_priv);
        cap_pc    = exc_pc;
        cap_tval  = exc_tval;
`ifdef TRAP_IRQ_EN
        if (!exc_found && irq_global_en && irq_found) begin
            cap_take  = 1'b1;
            cap_irq   = 1'b1;
            cap_cause = irq_cause;
            cap_pc    = irq_pc;
            cap_tval  = '0;
        end
`endif
    end

    // Capture in IDLE -> flush handshake -> commit handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            trap_irq   <= 1'b0;
            trap_cause <= 5'd0;
            trap_pc    <= '0;
            trap_tval  <= '0;
            trap_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cap_take) begin
                        state      <= ST_FLUSH;
                        trap_irq   <= cap_irq;
                        trap_cause <= cap_cause;
                        trap_pc    <= cap_pc;
                        trap_tval  <= cap_tval;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (trap_ready) begin
                        state      <= ST_IDLE;
                        trap_count <= sat_inc(trap_count);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign flush_req  = (state == ST_FLUSH);
    assign trap_valid = (state == ST_COMMIT);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk;
    logic                    reset;
    logic [1:0]              current_priv;
    logic [NUM_SRC-1:0]      src_valid;
    logic [5*NUM_SRC-1:0]    src_cause;
    logic [XLEN*NUM_SRC-1:0] src_pc;
    logic [XLEN*NUM_SRC-1:0] src_tval;
    logic [11:0]             irq_pending;
    logic                    irq_global_en;
    logic [XLEN-1:0]         irq_pc;
    logic                    flush_req;
    logic                    flush_done;
    logic                    trap_valid;
    logic                    trap_ready;
    logic                    trap_irq;
    logic [4:0]              trap_cause;
    logic [XLEN-1:0]         trap_pc;
    logic [XLEN-1:0]         trap_tval;
    logic                    busy;
    logic [CNT_W-1:0]        trap_count;

    trap_sequencer #(
        .XLEN    (XLEN),
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .current_priv  (current_priv),
        .src_valid     (src_valid),
        .src_cause     (src_cause),
        .src_pc        (src_pc),
        .src_tval      (src_tval),
        .irq_pending   (irq_pending),
        .irq_global_en (irq_global_en),
        .irq_pc        (irq_pc),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .trap_valid    (trap_valid),
        .trap_ready    (trap_ready),
        .trap_irq      (trap_irq),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .trap_tval     (trap_tval),
        .busy          (busy),
        .trap_count    (trap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    // Per-source stimulus, packed onto the DUT buses by apply()
    bit          s_valid [NUM_SRC];
    logic [4:0]  s_cause [NUM_SRC];
    logic [31:0] s_pc    [NUM_SRC];
    logic [31:0] s_tval  [NUM_SRC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_valid[i]            = s_valid[i];
            src_cause[5*i +: 5]     = s_cause[i];
            src_pc[XLEN*i +: XLEN]  = s_pc[i];
            src_tval[XLEN*i +: XLEN] = s_tval[i];
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            s_valid[i] = 1'b0;
            s_cause[i] = 5'd0;
            s_pc[i]    = 32'd0;
            s_tval[i]  = 32'd0;
        end
        irq_pending   = 12'd0;
        irq_global_en = 1'b0;
        irq_pc        = 32'd0;
        apply();
    endtask

    task automatic rand_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            s_valid[i] = ($urandom_range(3) == 0);
            s_cause[i] = ($urandom_range(3) == 0) ? 5'd8 : 5'($urandom_range(31));
            s_pc[i]    = $urandom;
            s_tval[i]  = $urandom;
        end
        current_priv  = 2'($urandom_range(3));
        irq_pending   = ($urandom_range(2) == 0) ? 12'd0 : 12'($urandom_range(4095));
        irq_global_en = 1'($urandom_range(1));
        irq_pc        = $urandom;
        apply();
    endtask

    // Reference: what trap (if any) the current inputs should produce.
    task automatic predict(output bit f, output bit e_irq, output logic [4:0] e_cause,
                           output logic [31:0] e_pc, output logic [31:0] e_tval);
        int idx[$];
        int order[6] = '{11, 3, 7, 9, 1, 5};
        f = 0; e_irq = 0; e_cause = 0; e_pc = 0; e_tval = 0;
        for (int i = 0; i < NUM_SRC; i++)
            if (s_valid[i]) idx.push_back(i);
        if (idx.size() > 0) begin
            f      = 1;
            e_pc   = s_pc[idx[0]];
            e_tval = s_tval[idx[0]];
            if (s_cause[idx[0]] == 5'd8)
                e_cause = (current_priv == 2'b10) ? 5'd11 : 5'(8 + int'(current_priv));
            else
                e_cause = s_cause[idx[0]];
        end
`ifdef TRAP_IRQ_EN
        else if (irq_global_en) begin
            foreach (order[k]) begin
                if (!f && irq_pending[order[k]]) begin
                    f = 1; e_irq = 1; e_cause = 5'(order[k]); e_pc = irq_pc; e_tval = 0;
                end
            end
        end
`endif
    endtask

    // Runs one trap from the current inputs. fwait/rwait stretch the flush and
    // commit handshakes; noise scrambles inputs that must be ignored meanwhile.
    task automatic run_trap(input string tag, input int fwait, input int rwait, input bit noise);
        bit f, e_irq;
        logic [4:0]  e_cause;
        logic [31:0] e_pc, e_tval;
        predict(f, e_irq, e_cause, e_pc, e_tval);
        flush_done = 1'b0;
        trap_ready = 1'b0;
        step();
        if (!f) begin
            chk({tag, "/idle_busy"}, busy, 0);
            chk({tag, "/idle_flush"}, flush_req, 0);
            return;
        end
        chk({tag, "/flush_req"}, flush_req, 1);
        chk({tag, "/busy"}, busy, 1);
        for (int k = 0; k < fwait; k++) begin
            if (noise) begin
                rand_srcs();
                trap_ready = 1'($urandom_range(1));
            end
            step();
            chk({tag, "/flush_hold"}, flush_req, 1);
            chk({tag, "/no_valid"}, trap_valid, 0);
        end
        flush_done = 1'b1;
        trap_ready = 1'b0;
        step();
        chk({tag, "/flush_drop"}, flush_req, 0);
        chk({tag, "/valid"}, trap_valid, 1);
        chk({tag, "/irq"}, trap_irq, e_irq);
        chk({tag, "/cause"}, trap_cause, e_cause);
        chk({tag, "/pc"}, trap_pc, e_pc);
        chk({tag, "/tval"}, trap_tval, e_tval);
        for (int k = 0; k < rwait; k++) begin
            if (noise) begin
                rand_srcs();
                flush_done = 1'($urandom_range(1));
            end
            step();
            chk({tag, "/valid_hold"}, trap_valid, 1);
            chk({tag, "/cause_hold"}, trap_cause, e_cause);
            chk({tag, "/pc_hold"}, trap_pc, e_pc);
            chk({tag, "/tval_hold"}, trap_tval, e_tval);
            chk({tag, "/cnt_hold"}, trap_count, exp_cnt);
        end
        clear_srcs();
        flush_done = 1'b0;
        trap_ready = 1'b1;
        step();
        if (exp_cnt < CNT_MAX) exp_cnt++;
        chk({tag, "/idle"}, busy, 0);
        chk({tag, "/valid_drop"}, trap_valid, 0);
        chk({tag, "/count"}, trap_count, exp_cnt);
        trap_ready = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        current_priv = 2'b11;
        flush_done   = 1'b0;
        trap_ready   = 1'b0;
        clear_srcs();
        #12;
        chk("rst/flush_req", flush_req, 0);
        chk("rst/trap_valid", trap_valid, 0);
        chk("rst/busy", busy, 0);
        chk("rst/count", trap_count, 0);
        reset = 1'b0;
        step();

        // Reset while committing the very first trap
        s_valid[0] = 1; s_cause[0] = 5'd5; s_pc[0] = 32'h44; s_tval[0] = 32'h55;
        apply();
        flush_done = 1'b1;
        step();
        step();
        chk("rstc/valid_before", trap_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstc/valid", trap_valid, 0);
        chk("rstc/flush_req", flush_req, 0);
        chk("rstc/busy", busy, 0);
        chk("rstc/irq", trap_irq, 0);
        chk("rstc/cause", trap_cause, 0);
        chk("rstc/pc", trap_pc, 0);
        chk("rstc/tval", trap_tval, 0);
        chk("rstc/count", trap_count, 0);
        clear_srcs();
        flush_done = 1'b0;
        #2 reset = 1'b0;
        step();

        // Single exception with both handshakes held high; source stays valid
        s_valid[2] = 1; s_cause[2] = 5'd2; s_pc[2] = 32'h100; s_tval[2] = 32'hDEAD;
        apply();
        flush_done = 1'b1;
        trap_ready = 1'b1;
        step();
        chk("single/flush_req", flush_req, 1);
        chk("single/no_valid", trap_valid, 0);
        step();
        chk("single/valid", trap_valid, 1);
        chk("single/cause", trap_cause, 2);
        chk("single/pc", trap_pc, 32'h100);
        chk("single/tval", trap_tval, 32'hDEAD);
        step();
        chk("single/idle", busy, 0);
        chk("single/count", trap_count, 1);
        step();
        chk("single/rearb", busy, 1);
        clear_srcs();
        step();
        step();
        chk("single/count2", trap_count, 2);
        exp_cnt = 2;
        flush_done = 1'b0;
        trap_ready = 1'b0;

        // Source priority
        s_valid[1] = 1; s_cause[1] = 5'd13; s_pc[1] = 32'h1111; s_tval[1] = 32'h2222;
        s_valid[3] = 1; s_cause[3] = 5'd3;  s_pc[3] = 32'h3333; s_tval[3] = 32'h4444;
        apply();
        run_trap("prio", 0, 0, 0);

        // ECALL rewrite from U, S and M
        current_priv = 2'b00; s_valid[0] = 1; s_cause[0] = 5'd8; s_pc[0] = 32'h10; apply();
        run_trap("ecall_u", 0, 0, 0);
        current_priv = 2'b01; s_valid[0] = 1; s_cause[0] = 5'd8; s_pc[0] = 32'h14; apply();
        run_trap("ecall_s", 0, 0, 0);
        current_priv = 2'b11; s_valid[0] = 1; s_cause[0] = 5'd8; s_pc[0] = 32'h18; apply();
        run_trap("ecall_m", 0, 0, 0);

        // Interrupt priority and exception-over-interrupt
        irq_pending = 12'h0A0; irq_global_en = 1'b1; irq_pc = 32'h200; apply();
        run_trap("irq", 0, 0, 0);
        irq_pending = 12'h0A0; irq_global_en = 1'b1; irq_pc = 32'h200;
        s_valid[0] = 1; s_cause[0] = 5'd1; s_pc[0] = 32'h300; s_tval[0] = 32'h7; apply();
        run_trap("irq_vs_exc", 0, 0, 0);

        // Handshake stall with new requests arriving during both waits
        s_valid[3] = 1; s_cause[3] = 5'd6; s_pc[3] = 32'hABC0; s_tval[3] = 32'h1234; apply();
        run_trap("stall", 5, 3, 1);

        // Randomized traffic; trap_count saturates along the way
        for (int n = 0; n < 40; n++) begin
            rand_srcs();
            run_trap("rand", $urandom_range(3), $urandom_range(3), 1);
        end
        chk("sat/count", trap_count, exp_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
